fetcher: RTL and testbench

FETCHER -- requirements
Module: fetcher

---
 rtl/fetcher.sv | 159 +++++++++++++++
 tb/tb_fetcher.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetcher.sv
// Instruction fetcher: issues sequential instruction-memory reads, buffers
// returned words with their addresses in a small FIFO for the decoder, and
// handles fetch redirects (jumps), including redirects that arrive while a
// read is still outstanding.
module fetcher #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memData,
    input  logic        jumpEn,
    input  logic [31:0] jumpAddr,
    input  logic        stall,
    output logic        instValid,
    output logic [31:0] inst,
    output logic [31:0] instPc
);

    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [31:0]   pc, pc_nxt;
    logic          memReq_nxt;
    logic [31:0]   memAddr_nxt;

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, count_after;
    logic          push, pop;

    logic [31:0]   qpc  [QUEUE_DEPTH];
    logic [31:0]   qword[QUEUE_DEPTH];

    // Queue handshakes: a jump overrides both push and pop
    always_comb begin
        push        = (state == REQ) && memAck && !jumpEn;
        pop         = (count != '0) && !stall && !jumpEn;
        count_after = count + CW'(push) - CW'(pop);
    end

    // Fetch FSM next-state and request/address decisions
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        memReq_nxt  = memReq;
        memAddr_nxt = memAddr;
        case (state)
            IDLE: begin
                if (jumpEn) begin
                    pc_nxt      = jumpAddr;
                    memReq_nxt  = 1'b1;
                    memAddr_nxt = jumpAddr;
                    state_nxt   = REQ;
                end else if (count != FULL) begin
                    memReq_nxt  = 1'b1;
                    memAddr_nxt = pc;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                if (memAck) begin
                    if (jumpEn) begin
                        pc_nxt      = jumpAddr;
                        memReq_nxt  = 1'b1;
                        memAddr_nxt = jumpAddr;
                    end else begin
                        pc_nxt      = memAddr + 32'd4;
                        memAddr_nxt = memAddr + 32'd4;
                        if (count_after < FULL) begin
                            memReq_nxt = 1'b1;
                        end else begin
                            memReq_nxt = 1'b0;
                            state_nxt  = IDLE;
                        end
                    end
                end else if (jumpEn) begin
                    pc_nxt    = jumpAddr;
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                // The stale read must complete before the redirect target is
                // requested; a jump coinciding with that ack goes straight out.
                if (memAck) begin
                    memReq_nxt = 1'b1;
                    state_nxt  = REQ;
                    if (jumpEn) begin
                        pc_nxt      = jumpAddr;
                        memAddr_nxt = jumpAddr;
                    end else begin
                        memAddr_nxt = pc;
                    end
                end else if (jumpEn) begin
                    pc_nxt = jumpAddr;
                end
            end
            default: begin
                state_nxt  = IDLE;
                memReq_nxt = 1'b0;
            end
        endcase
    end

    // FSM, fetch pointer and memory request registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            memReq  <= 1'b0;
            memAddr <= RESET_PC;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            memReq  <= memReq_nxt;
            memAddr <= memAddr_nxt;
        end
    end

    // Queue pointers and occupancy; a jump flushes the queue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (jumpEn) begin
            tail  <= head;
            count <= '0;
        end else begin
            head  <= head + PW'(pop);
            tail  <= tail + PW'(push);
            count <= count_after;
        end
    end

    // Queue storage: write returned word with its fetch address at the tail
    always_ff @(posedge clk) begin
        if (push) begin
            qpc[tail]   <= memAddr;
            qword[tail] <= memData;
        end
    end

    // Decoder outputs straight from the head entry
    always_comb begin
        instValid = (count != '0);
        inst      = qword[head];
        instPc    = qpc[head];
    end

endmodule

// File: tb/tb_fetcher.sv
// Scoreboard bench for fetcher: stimulus pushes expected fetch addresses,
// a negedge monitor pops and compares every instruction the decoder takes.
module tb_fetcher;

    logic        clk;
    logic        rst;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memData;
    logic        jumpEn;
    logic [31:0] jumpAddr;
    logic        stall;
    logic        instValid;
    logic [31:0] inst;
    logic [31:0] instPc;

    logic        ack_en;
    logic        ack_force;

    int passed = 0;
    int total  = 0;

    logic [31:0] sb[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h5A5A_1234;
    endfunction

    assign memAck  = ack_force | (memReq & ack_en);
    assign memData = word_of(memAddr);

    fetcher #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .memReq(memReq), .memAddr(memAddr), .memAck(memAck), .memData(memData),
        .jumpEn(jumpEn), .jumpAddr(jumpAddr), .stall(stall),
        .instValid(instValid), .inst(inst), .instPc(instPc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every decoder pop is checked against the oldest expected entry
    always @(negedge clk) begin
        if (rst && instValid && !stall && !jumpEn) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_pop: got pc %h expected none", instPc);
            end else begin
                logic [31:0] epc;
                epc = sb.pop_front();
                check("instPc", instPc, epc);
                check("inst", inst, word_of(epc));
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b0; jumpEn = 1'b0; stall = 1'b0; ack_en = 1'b0; ack_force = 1'b0;
        sb.delete();
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        check("drain", 32'(sb.size()), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1; jumpEn = 1'b0; jumpAddr = '0; stall = 1'b0;
        ack_en = 1'b0; ack_force = 1'b0;
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_memReq", 32'(memReq), 32'd0);
        check("rst_memAddr", memAddr, 32'h0);
        check("rst_instValid", 32'(instValid), 32'd0);

        // Continuous fetch, memAck tied to memReq, no stall
        apply_reset();
        ack_en = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("seq_memReq", 32'(memReq), 32'd1);
            check("seq_memAddr", memAddr, 32'(4 * i));
            if (i > 0) check("seq_latency_valid", 32'(instValid), 32'd1);
            sb.push_back(32'(4 * i));
            tick();
        end
        ack_en = 1'b0;
        drain();

        // Stall held: queue fills with four entries then fetch parks
        apply_reset();
        stall = 1'b1; ack_en = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fill_memAddr", memAddr, 32'(4 * i));
            sb.push_back(32'(4 * i));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_memReq", 32'(memReq), 32'd0);
            check("full_instPc", instPc, 32'h0);
            tick();
        end
        ack_en = 1'b0; stall = 1'b0;
        drain();
        @(negedge clk);
        check("resume_memReq", 32'(memReq), 32'd1);
        check("resume_memAddr", memAddr, 32'h10);

        // Jump while request at 0x8 is outstanding, ack three cycles later
        apply_reset();
        ack_en = 1'b1;
        tick(); sb.push_back(32'h0);
        tick(); sb.push_back(32'h4);
        tick(); ack_en = 1'b0;
        tick(); tick();
        jumpEn = 1'b1; jumpAddr = 32'h100;
        @(negedge clk);
        check("disc_jump_memAddr", memAddr, 32'h8);
        tick(); jumpEn = 1'b0;
        @(negedge clk);
        check("disc_memReq", 32'(memReq), 32'd1);
        check("disc_memAddr0", memAddr, 32'h8);
        check("disc_instValid", 32'(instValid), 32'd0);
        tick();
        @(negedge clk);
        check("disc_memAddr1", memAddr, 32'h8);
        tick(); ack_en = 1'b1;
        @(negedge clk);
        check("disc_memAddr2", memAddr, 32'h8);
        tick();
        @(negedge clk);
        check("disc_target_memReq", 32'(memReq), 32'd1);
        check("disc_target_memAddr", memAddr, 32'h100);
        sb.push_back(32'h100);
        tick(); ack_en = 1'b0;
        drain();

        // Jump in the same cycle as the ack of 0xC
        apply_reset();
        ack_en = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            sb.push_back(32'(4 * i));
            tick();
        end
        jumpEn = 1'b1; jumpAddr = 32'h40;
        sb.delete();
        @(negedge clk);
        check("jack_memAddr", memAddr, 32'hC);
        tick(); jumpEn = 1'b0;
        @(negedge clk);
        check("jack_memReq", 32'(memReq), 32'd1);
        check("jack_memAddr_next", memAddr, 32'h40);
        check("jack_instValid", 32'(instValid), 32'd0);
        sb.push_back(32'h40);
        tick(); ack_en = 1'b0;
        drain();

        // Address wraps from 0xFFFFFFFC to 0
        apply_reset();
        tick();
        jumpEn = 1'b1; jumpAddr = 32'hFFFF_FFFC; ack_en = 1'b1;
        tick(); jumpEn = 1'b0;
        @(negedge clk);
        check("wrap_memAddr0", memAddr, 32'hFFFF_FFFC);
        sb.push_back(32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        check("wrap_memAddr1", memAddr, 32'h0);
        sb.push_back(32'h0);
        tick(); ack_en = 1'b0;
        drain();

        // Asynchronous reset with a request outstanding and three entries queued
        apply_reset();
        stall = 1'b1; ack_en = 1'b1;
        repeat (4) tick();
        ack_en = 1'b0;
        @(negedge clk);
        check("pre_rst_instValid", 32'(instValid), 32'd1);
        check("pre_rst_memAddr", memAddr, 32'hC);
        check("pre_rst_memReq", 32'(memReq), 32'd1);
        #2;
        rst = 1'b0; ack_force = 1'b1;
        #1;
        check("async_memReq", 32'(memReq), 32'd0);
        check("async_instValid", 32'(instValid), 32'd0);
        check("async_memAddr", memAddr, 32'h0);
        tick(); tick();
        check("rst_hold_instValid", 32'(instValid), 32'd0);
        ack_force = 1'b0; stall = 1'b0; rst = 1'b1; ack_en = 1'b1;
        tick();
        @(negedge clk);
        check("restart_memReq", 32'(memReq), 32'd1);
        check("restart_memAddr", memAddr, 32'h0);
        sb.push_back(32'h0);
        tick(); ack_en = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
